// File: rtl/ob_pkg.sv
// Order-book shared types: opcodes and the command record carried between stages.
package ob_pkg;

  typedef enum logic [3:0] {
    Op_None          = 4'd0,
    Op_BuyLimit      = 4'd1,
    Op_SellLimit     = 4'd2,
    Op_BuyMarket     = 4'd3,
    Op_SellMarket    = 4'd4,
    Op_Cancel        = 4'd5,
    Op_BuyStopLoss   = 4'd6,
    Op_BuyStopLimit  = 4'd7,
    Op_SellStopLoss  = 4'd8,
    Op_SellStopLimit = 4'd9
  } op_t;

  typedef struct packed {
    op_t         opc;
    logic [15:0] oid;
    logic [31:0] price;
    logic [31:0] qty;
  } cmd_t;

endpackage

// File: rtl/ob_cn_issue.sv
// ob_cn_issue: picks matured conditional-table entries round-robin, converts the
// stored stop command into its executable opcode and hands it to the order-book
// issue path over valid/ready. The entry is released with a one-hot dl_vld pulse
// on acceptance (or immediately when its opcode is not a stop opcode).
// Optional feature: define OB_CN_ISSUE_CNT_EN to add the 32-bit accepted-issue
// counter on port issue_cnt_r.
module ob_cn_issue #(
  parameter int N = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            mtr_r,
  input  ob_pkg::cmd_t [N-1:0]    mtr_cmd_r,
  output logic [N-1:0]            dl_vld,
  output logic                    iss_vld_r,
  output ob_pkg::cmd_t            iss_cmd_r,
  input  logic                    iss_rdy,
  output logic                    err_vld_r,
  output logic                    busy_r
`ifdef OB_CN_ISSUE_CNT_EN
  ,
  output logic [31:0]             issue_cnt_r
`endif
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DROP
  } state_t;

  state_t              state_r;
  state_t              state_nx;
  logic [IW-1:0]       ptr_r;
  logic [IW-1:0]       idx_r;
  logic [N-1:0]        dl_mask_r;
  logic [N-1:0]        cand;
  logic [IW:0]         gnt;
  logic                gnt_any;
  logic [IW-1:0]       gnt_idx;
  ob_pkg::cmd_t        gnt_cmd;
  ob_pkg::cmd_t        conv_cmd;
  logic                conv_ok;

  // Next index after i, wrapping at N-1 (N need not be a power of two).
  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
    if (N == 1) return '0;
    if (int'(i) >= N - 1) return '0;
    return i + IW'(1);
  endfunction

  // Lowest set bit of c at or above p, wrapping to 0. MSB of result = found.
  function automatic logic [IW:0] rr_pick(input logic [N-1:0] c,
                                          input logic [IW-1:0] p);
    logic [IW:0] r;
    int          j;
    r = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(p) + k;
      if (j >= N) j = j - N;
      if (c[j[IW-1:0]]) r = {1'b1, j[IW-1:0]};
    end
    return r;
  endfunction

  // Only the four stop opcodes have an executable form.
  function automatic logic stop_valid(input ob_pkg::op_t o);
    return o inside {ob_pkg::Op_BuyStopLoss, ob_pkg::Op_BuyStopLimit,
                     ob_pkg::Op_SellStopLoss, ob_pkg::Op_SellStopLimit};
  endfunction

  // Stop opcode -> executable opcode; every other field is carried through.
  function automatic ob_pkg::cmd_t stop_convert(input ob_pkg::cmd_t c);
    ob_pkg::cmd_t r;
    r = c;
    case (c.opc)
      ob_pkg::Op_BuyStopLoss:   r.opc = ob_pkg::Op_BuyMarket;
      ob_pkg::Op_BuyStopLimit:  r.opc = ob_pkg::Op_BuyLimit;
      ob_pkg::Op_SellStopLoss:  r.opc = ob_pkg::Op_SellMarket;
      ob_pkg::Op_SellStopLimit: r.opc = ob_pkg::Op_SellLimit;
      default:                  r.opc = c.opc;
    endcase
    return r;
  endfunction

  // The entry released last cycle may still show its matured flag; hide it.
  assign cand     = mtr_r & ~dl_mask_r;
  assign gnt      = rr_pick(cand, ptr_r);
  assign gnt_any  = gnt[IW];
  assign gnt_idx  = gnt[IW-1:0];
  assign gnt_cmd  = mtr_cmd_r[gnt_idx];
  assign conv_cmd = stop_convert(gnt_cmd);
  assign conv_ok  = stop_valid(gnt_cmd.opc);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= S_IDLE;
    else     state_r <= state_nx;
  end

  // Next state and the combinational deallocate strobe.
  always_comb begin
    state_nx = state_r;
    dl_vld   = '0;
    case (state_r)
      S_IDLE: begin
        if (gnt_any) state_nx = conv_ok ? S_ISSUE : S_DROP;
      end
      S_ISSUE: begin
        if (iss_rdy) begin
          dl_vld   = N'(1) << idx_r;
          state_nx = S_IDLE;
        end
      end
      S_DROP: begin
        dl_vld   = N'(1) << idx_r;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Arbiter pointer, latched index, release mask and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r     <= '0;
      idx_r     <= '0;
      dl_mask_r <= '0;
      iss_vld_r <= 1'b0;
      err_vld_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      dl_mask_r <= dl_vld;
      if (state_r == S_IDLE && gnt_any) begin
        ptr_r <= wrap_inc(gnt_idx);
        idx_r <= gnt_idx;
      end
      iss_vld_r <= (state_nx == S_ISSUE);
      err_vld_r <= (state_nx == S_DROP);
      busy_r    <= (state_nx != S_IDLE);
    end
  end

  // Issued command: captured on grant of a valid stop command, held until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_cmd_r <= '0;
    end else if (state_r == S_IDLE && gnt_any && conv_ok) begin
      iss_cmd_r <= conv_cmd;
    end
  end

`ifdef OB_CN_ISSUE_CNT_EN
  // Accepted-issue counter; drops are not counted, wraps naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              issue_cnt_r <= '0;
    else if (state_r == S_ISSUE && iss_rdy) issue_cnt_r <= issue_cnt_r + 32'd1;
  end
`endif

endmodule

// File: tb/tb_ob_cn_issue.sv
// Bench for ob_cn_issue: directed scenarios against a transaction-level model of
// the issue stage, plus a conditional-table emulation that drops an entry's
// matured flag two edges after its dl_vld pulse.
module tb_ob_cn_issue;
  import ob_pkg::*;

  localparam int N  = 16;
  localparam int IW = $clog2(N);

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   mtr_r = '0;
  cmd_t [N-1:0]   mtr_cmd_r;
  logic           iss_rdy = 1'b0;
  logic [N-1:0]   dl_vld;
  logic           iss_vld_r;
  cmd_t           iss_cmd_r;
  logic           err_vld_r;
  logic           busy_r;
`ifdef OB_CN_ISSUE_CNT_EN
  logic [31:0]    issue_cnt_r;
`endif

  int n_vec = 0;
  int n_bad = 0;
  int acc_q[$];

  always #5 clk = ~clk;

  ob_cn_issue #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .mtr_r     (mtr_r),
    .mtr_cmd_r (mtr_cmd_r),
    .dl_vld    (dl_vld),
    .iss_vld_r (iss_vld_r),
    .iss_cmd_r (iss_cmd_r),
    .iss_rdy   (iss_rdy),
    .err_vld_r (err_vld_r),
    .busy_r    (busy_r)
`ifdef OB_CN_ISSUE_CNT_EN
    ,
    .issue_cnt_r (issue_cnt_r)
`endif
  );

  // ---------------- reference model ----------------
  logic           m_act = 1'b0;
  logic           m_drop = 1'b0;
  int             m_idx = 0;
  int             m_ptr = 0;
  cmd_t           m_cmd;
  logic [N-1:0]   m_mask = '0;
  logic [31:0]    m_cnt = '0;

  function automatic logic is_stop(op_t o);
    return o inside {Op_BuyStopLoss, Op_BuyStopLimit, Op_SellStopLoss, Op_SellStopLimit};
  endfunction

  function automatic cmd_t to_exec(cmd_t c);
    cmd_t r;
    r = c;
    case (c.opc)
      Op_BuyStopLoss:   r.opc = Op_BuyMarket;
      Op_BuyStopLimit:  r.opc = Op_BuyLimit;
      Op_SellStopLoss:  r.opc = Op_SellMarket;
      Op_SellStopLimit: r.opc = Op_SellLimit;
      default:          r.opc = c.opc;
    endcase
    return r;
  endfunction

  // First requesting entry met when walking upward from p, wrapping; -1 if none.
  function automatic int rr_pick(logic [N-1:0] c, int p);
    logic [IW-1:0] ii;
    for (int k = 0; k < N; k++) begin
      ii = IW'((p + k) % N);
      if (c[ii]) return int'(ii);
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_dl(logic act, logic drop, int idx, logic rdy);
    if (act && (drop || rdy)) return N'(1) << idx;
    return '0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act  <= 1'b0;
      m_drop <= 1'b0;
      m_idx  <= 0;
      m_ptr  <= 0;
      m_cmd  <= '0;
      m_mask <= '0;
      m_cnt  <= '0;
    end else begin
      m_mask <= model_dl(m_act, m_drop, m_idx, iss_rdy);
      if (m_act) begin
        if (m_drop || iss_rdy) begin
          m_act <= 1'b0;
          if (!m_drop) m_cnt <= m_cnt + 32'd1;
        end
      end else if (rr_pick(mtr_r & ~m_mask, m_ptr) >= 0) begin
        m_act  <= 1'b1;
        m_idx  <= rr_pick(mtr_r & ~m_mask, m_ptr);
        m_ptr  <= (rr_pick(mtr_r & ~m_mask, m_ptr) + 1) % N;
        m_drop <= !is_stop(mtr_cmd_r[IW'(rr_pick(mtr_r & ~m_mask, m_ptr))].opc);
        m_cmd  <= to_exec(mtr_cmd_r[IW'(rr_pick(mtr_r & ~m_mask, m_ptr))]);
      end
    end
  end

  // Table emulation: released entry's flag is still seen at the next edge.
  logic [N-1:0] dl_d1 = '0;
  logic [N-1:0] dl_d2 = '0;
  always @(posedge clk) begin
    dl_d1 <= dl_vld;
    dl_d2 <= dl_d1;
  end

  // ---------------- checking ----------------
  task automatic chk(string nm, logic [127:0] got, logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, then advance to the next negedge.
  task automatic tick();
    #1;
    chk("iss_vld", 128'(iss_vld_r), 128'(m_act && !m_drop));
    chk("err_vld", 128'(err_vld_r), 128'(m_act && m_drop));
    chk("busy",    128'(busy_r),    128'(m_act));
    chk("dl_vld",  128'(dl_vld),    128'(model_dl(m_act, m_drop, m_idx, iss_rdy)));
    if (m_act && !m_drop) chk("iss_cmd", 128'(iss_cmd_r), 128'(m_cmd));
`ifdef OB_CN_ISSUE_CNT_EN
    chk("issue_cnt", 128'(issue_cnt_r), 128'(m_cnt));
`endif
    if (iss_vld_r && iss_rdy) begin
      for (int i = 0; i < N; i++) if (dl_vld[i]) acc_q.push_back(i);
    end
    @(negedge clk);
    mtr_r = mtr_r & ~dl_d2;
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  function automatic cmd_t mk(op_t o, logic [31:0] p, logic [31:0] q);
    cmd_t c;
    c.opc   = o;
    c.oid   = 16'h0A50 + q[15:0];
    c.price = p;
    c.qty   = q;
    return c;
  endfunction

  initial begin
    int n0;
    mtr_cmd_r = '0;
    rst = 1'b1;
    iss_rdy = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_iss_vld", 128'(iss_vld_r), 128'(0));
    chk("rst_busy",    128'(busy_r),    128'(0));
    chk("rst_dl",      128'(dl_vld),    128'(0));
    chk("rst_cmd",     128'(iss_cmd_r), 128'(0));
    tick();
    rst = 1'b0;
    tick();

    // single entry, immediate acceptance
    mtr_cmd_r[3] = mk(Op_BuyStopLimit, 100, 10);
    mtr_r[3] = 1'b1;
    iss_rdy = 1'b1;
    tick();
    #1;
    chk("t1_vld",   128'(iss_vld_r),       128'(1));
    chk("t1_opc",   128'(iss_cmd_r.opc),   128'(Op_BuyLimit));
    chk("t1_price", 128'(iss_cmd_r.price), 128'(100));
    chk("t1_dl",    128'(dl_vld),          128'(16'h0008));
    tick();
    #1;
    chk("t1_idle_vld",  128'(iss_vld_r), 128'(0));
    chk("t1_idle_busy", 128'(busy_r),    128'(0));
    chk("t1_idle_dl",   128'(dl_vld),    128'(0));
    tick();
    idle(4);

    // backpressure on entry 0
    mtr_cmd_r[0] = mk(Op_SellStopLoss, 55, 3);
    mtr_r[0] = 1'b1;
    iss_rdy = 1'b0;
    tick();
    repeat (5) begin
      #1;
      chk("bp_vld",   128'(iss_vld_r),       128'(1));
      chk("bp_opc",   128'(iss_cmd_r.opc),   128'(Op_SellMarket));
      chk("bp_price", 128'(iss_cmd_r.price), 128'(55));
      chk("bp_dl",    128'(dl_vld),          128'(0));
      tick();
    end
    iss_rdy = 1'b1;
    #1;
    chk("bp_acc_dl", 128'(dl_vld), 128'(16'h0001));
    tick();
    #1;
    chk("bp_after_dl", 128'(dl_vld), 128'(0));
    tick();
    idle(4);

    // bring the pointer to 6 by issuing entry 5, then three simultaneous entries
    mtr_cmd_r[5] = mk(Op_BuyStopLoss, 70, 1);
    mtr_r[5] = 1'b1;
    tick();
    idle(5);
    n0 = acc_q.size();
    mtr_cmd_r[1]  = mk(Op_SellStopLimit, 11, 21);
    mtr_cmd_r[5]  = mk(Op_BuyStopLimit, 55, 22);
    mtr_cmd_r[14] = mk(Op_SellStopLoss, 144, 23);
    mtr_r = mtr_r | 16'h4022;
    idle(12);
    chk("rr_count", 128'(acc_q.size() - n0), 128'(3));
    chk("rr_first",  128'(acc_q[n0]),     128'(14));
    chk("rr_second", 128'(acc_q[n0 + 1]), 128'(1));
    chk("rr_third",  128'(acc_q[n0 + 2]), 128'(5));

    // non-stop opcode is dropped
    mtr_cmd_r[2] = mk(Op_BuyLimit, 20, 4);
    mtr_r[2] = 1'b1;
    iss_rdy = 1'b0;
    tick();
    #1;
    chk("inv_err", 128'(err_vld_r), 128'(1));
    chk("inv_dl",  128'(dl_vld),    128'(16'h0004));
    chk("inv_vld", 128'(iss_vld_r), 128'(0));
    tick();
    #1;
    chk("inv_err_off", 128'(err_vld_r), 128'(0));
    chk("inv_vld_off", 128'(iss_vld_r), 128'(0));
    tick();
    idle(4);

    // asynchronous reset while an issue is pending
    mtr_cmd_r[7] = mk(Op_BuyStopLoss, 77, 5);
    mtr_r[7] = 1'b1;
    iss_rdy = 1'b0;
    tick();
    tick();
    #1;
    chk("rm_pre_vld", 128'(iss_vld_r), 128'(1));
    #1;
    rst = 1'b1;
    #1;
    chk("rm_vld",  128'(iss_vld_r), 128'(0));
    chk("rm_busy", 128'(busy_r),    128'(0));
    chk("rm_dl",   128'(dl_vld),    128'(0));
    chk("rm_err",  128'(err_vld_r), 128'(0));
    chk("rm_cmd",  128'(iss_cmd_r), 128'(0));
    tick();
    rst = 1'b0;
    iss_rdy = 1'b1;
    tick();
    #1;
    chk("rm_post_vld", 128'(iss_vld_r),     128'(1));
    chk("rm_post_opc", 128'(iss_cmd_r.opc), 128'(Op_BuyMarket));
    chk("rm_post_dl",  128'(dl_vld),        128'(16'h0080));
    tick();
    idle(4);

    // three accepted issues and one drop after a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    n0 = acc_q.size();
    mtr_cmd_r[9]  = mk(Op_BuyStopLimit, 900, 31);
    mtr_cmd_r[10] = mk(Op_Cancel, 1000, 32);
    mtr_cmd_r[11] = mk(Op_SellStopLimit, 1100, 33);
    mtr_cmd_r[12] = mk(Op_SellStopLoss, 1200, 34);
    mtr_r = mtr_r | 16'h1E00;
    iss_rdy = 1'b1;
    idle(14);
    chk("cnt_accepts", 128'(acc_q.size() - n0), 128'(3));
    chk("cnt_order0",  128'(acc_q[n0]),     128'(9));
    chk("cnt_order2",  128'(acc_q[n0 + 2]), 128'(12));
`ifdef OB_CN_ISSUE_CNT_EN
    chk("cnt_value", 128'(issue_cnt_r), 128'(3));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
